rv_div_seq: RTL and testbench

Multi-cycle sequencer for M-extension DIV/DIVU/REM/REMU, added alongside the execute stage of the pipelined core. It owns a private instance of the core's shared ALU and drives it with SUB operations, one iteration per cycle, to perform restoring division. Operands arrive and results leave over valid/ready handshakes, so the hazard unit can stall EX while o_busy is high.

---
 rtl/rv_div_seq_pkg.sv | 39 +++
 rtl/rv_alu.sv | 28 ++
 rtl/rv_div_seq.sv | 167 ++++++++++++++++
 tb/tb_rv_div_seq.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_div_seq_pkg.sv
// Shared types and constants for the sequential M-extension divider.
// Operation and state encodings plus the ALU control codes reused from the core.
package rv_div_seq_pkg;

  localparam int DIV_XLEN  = 32;
  localparam int DIV_TAG_W = 5;

  localparam logic [3:0] SRC_ALU_CTRL_ADD  = 4'd0;
  localparam logic [3:0] SRC_ALU_CTRL_SUB  = 4'd1;
  localparam logic [3:0] SRC_ALU_CTRL_AND  = 4'd2;
  localparam logic [3:0] SRC_ALU_CTRL_OR   = 4'd3;
  localparam logic [3:0] SRC_ALU_CTRL_XOR  = 4'd4;
  localparam logic [3:0] SRC_ALU_CTRL_SLT  = 4'd5;
  localparam logic [3:0] SRC_ALU_CTRL_SLTU = 4'd6;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    DIV_ST_IDLE = 2'd0,
    DIV_ST_CALC = 2'd1,
    DIV_ST_FIX  = 2'd2,
    DIV_ST_DONE = 2'd3
  } div_state_e;

  // Bit 0 of the op selects unsigned, bit 1 selects remainder.
  function automatic logic f_op_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic f_op_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/rv_alu.sv
// Core integer ALU; the divider owns a private copy and uses only its SUB path.
// Purely combinational.
module rv_alu
  import rv_div_seq_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [3:0]      i_ctrl,
  output logic [XLEN-1:0] o_result
);

  always_comb begin
    o_result = '0;
    case (i_ctrl)
      SRC_ALU_CTRL_ADD:  o_result = i_a + i_b;
      SRC_ALU_CTRL_SUB:  o_result = i_a - i_b;
      SRC_ALU_CTRL_AND:  o_result = i_a & i_b;
      SRC_ALU_CTRL_OR:   o_result = i_a | i_b;
      SRC_ALU_CTRL_XOR:  o_result = i_a ^ i_b;
      SRC_ALU_CTRL_SLT:  o_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      SRC_ALU_CTRL_SLTU: o_result = {{(XLEN-1){1'b0}}, (i_a < i_b)};
      default:           o_result = '0;
    endcase
  end

endmodule

// File: rtl/rv_div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Request: accepted on a cycle with i_req_valid && o_req_ready; response: consumed on o_rsp_valid && i_rsp_ready, data/tag held until then.
module rv_div_seq
  import rv_div_seq_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic [1:0]           i_req_op,
  input  logic [XLEN-1:0]      i_req_a,
  input  logic [XLEN-1:0]      i_req_b,
  input  logic [DIV_TAG_W-1:0] i_req_tag,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [XLEN-1:0]      o_rsp_data,
  output logic [DIV_TAG_W-1:0] o_rsp_tag,
  input  logic                 i_flush,
  output logic                 o_busy,
  output logic [1:0]           o_dbg_state
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e           r_state;
  logic [1:0]           r_op;
  logic [DIV_TAG_W-1:0] r_tag;
  logic [XLEN-1:0]      r_div;
  logic [XLEN-1:0]      r_rem;
  logic [XLEN-1:0]      r_q;
  logic [XLEN-1:0]      r_data;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic                 r_valid;

  logic            w_signed;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_div0;
  logic            w_ovf;
  logic [XLEN-1:0] w_special_data;
  logic [XLEN-1:0] w_shifted;
  logic            w_msb;
  logic            w_ge;
  logic [XLEN-1:0] w_fix_val;
  logic            w_fix_neg;
  logic [XLEN-1:0] w_alu_a;
  logic [XLEN-1:0] w_alu_b;
  logic [XLEN-1:0] w_alu_res;

  assign w_signed = f_op_signed(i_req_op);
  assign w_a_mag  = (w_signed && i_req_a[XLEN-1]) ? (~i_req_a + 1'b1) : i_req_a;
  assign w_b_mag  = (w_signed && i_req_b[XLEN-1]) ? (~i_req_b + 1'b1) : i_req_b;
  assign w_div0   = (i_req_b == '0);
  assign w_ovf    = w_signed && (i_req_a == MIN_NEG) && (i_req_b == '1);

  // Divide-by-zero and signed overflow never enter the iteration loop.
  assign w_special_data = w_div0 ? (f_op_rem(i_req_op) ? i_req_a : '1)
                                 : (f_op_rem(i_req_op) ? '0 : MIN_NEG);

  // The remainder is effectively XLEN+1 bits wide; w_msb carries the top bit.
  assign w_shifted = {r_rem[XLEN-2:0], r_q[XLEN-1]};
  assign w_msb     = r_rem[XLEN-1];
  assign w_ge      = w_msb | (w_shifted >= r_div);

  assign w_fix_val = f_op_rem(r_op) ? r_rem : r_q;
  assign w_fix_neg = f_op_rem(r_op) ? r_neg_r : r_neg_q;

  always_comb begin
    w_alu_a = '0;
    w_alu_b = '0;
    case (r_state)
      DIV_ST_CALC: begin
        w_alu_a = w_shifted;
        w_alu_b = r_div;
      end
      DIV_ST_FIX: begin
        w_alu_a = '0;
        w_alu_b = w_fix_val;
      end
      default: begin
        w_alu_a = '0;
        w_alu_b = '0;
      end
    endcase
  end

  rv_alu #(.XLEN(XLEN)) u_alu (
    .i_a      (w_alu_a),
    .i_b      (w_alu_b),
    .i_ctrl   (SRC_ALU_CTRL_SUB),
    .o_result (w_alu_res)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= DIV_ST_IDLE;
      r_op    <= '0;
      r_tag   <= '0;
      r_div   <= '0;
      r_rem   <= '0;
      r_q     <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_state <= DIV_ST_IDLE;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        DIV_ST_IDLE: begin
          if (i_req_valid) begin
            r_op    <= i_req_op;
            r_tag   <= i_req_tag;
            r_div   <= w_b_mag;
            r_neg_q <= w_signed & (i_req_a[XLEN-1] ^ i_req_b[XLEN-1]);
            r_neg_r <= w_signed & i_req_a[XLEN-1];
            r_rem   <= '0;
            r_q     <= w_a_mag;
            r_cnt   <= '0;
            if (w_div0 || w_ovf) begin
              r_data  <= w_special_data;
              r_valid <= 1'b1;
              r_state <= DIV_ST_DONE;
            end else begin
              r_state <= DIV_ST_CALC;
            end
          end
        end
        DIV_ST_CALC: begin
          r_rem <= w_ge ? w_alu_res : w_shifted;
          r_q   <= {r_q[XLEN-2:0], w_ge};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(XLEN-1)) begin
            r_state <= DIV_ST_FIX;
          end
        end
        DIV_ST_FIX: begin
          r_data  <= w_fix_neg ? w_alu_res : w_fix_val;
          r_valid <= 1'b1;
          r_state <= DIV_ST_DONE;
        end
        DIV_ST_DONE: begin
          if (i_rsp_ready) begin
            r_valid <= 1'b0;
            r_state <= DIV_ST_IDLE;
          end
        end
        default: r_state <= DIV_ST_IDLE;
      endcase
    end
  end

  assign o_req_ready = (r_state == DIV_ST_IDLE) && !i_flush;
  assign o_busy      = (r_state != DIV_ST_IDLE);
  assign o_rsp_valid = r_valid;
  assign o_rsp_data  = r_data;
  assign o_rsp_tag   = r_tag;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_rv_div_seq.sv
// Bench for rv_div_seq: directed and random requests against an arithmetic
// reference model, with latency, hold, flush and async-reset scenarios.
module tb_rv_div_seq;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [1:0]  i_req_op = '0;
  logic [31:0] i_req_a = '0;
  logic [31:0] i_req_b = '0;
  logic [4:0]  i_req_tag = '0;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b1;
  logic [31:0] o_rsp_data;
  logic [4:0]  o_rsp_tag;
  logic        i_flush = 1'b0;
  logic        o_busy;
  logic [1:0]  o_dbg_state;

  rv_div_seq dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_op    (i_req_op),
    .i_req_a     (i_req_a),
    .i_req_b     (i_req_b),
    .i_req_tag   (i_req_tag),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_data  (o_rsp_data),
    .o_rsp_tag   (o_rsp_tag),
    .i_flush     (i_flush),
    .o_busy      (o_busy),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  logic [4:0]  tag_q[$];
  int          lat_q[$];
  int unsigned acc_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        rdy_rand = 1'b0;
  logic        rdy_force = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: RISC-V M-extension division semantics in plain arithmetic.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic sgn;
    logic is_rem;
    sgn    = !op[0];
    is_rem = op[1];
    if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_rem ? 32'd0 : 32'h8000_0000;
    if (sgn) return is_rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return is_rem ? (a % b) : (a / b);
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // ---------------- i_rsp_ready driver ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      i_rsp_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    end
  end

  // ---------------- request driver ----------------
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag, input logic track, input logic [31:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    while (!o_req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!o_req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_ready_timeout: o_req_ready=0 after %0d cycles, required 1", n);
      return;
    end
    i_req_valid = 1'b1;
    i_req_op    = op;
    i_req_a     = a;
    i_req_b     = b;
    i_req_tag   = tag;
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
    if (track) begin
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      lat_q.push_back(model_lat(op, a, b));
      acc_q.push_back(cyc);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete(); tag_q.delete(); lat_q.delete(); acc_q.delete();
    end
  endtask

  // ---------------- compare process ----------------
  logic seen_valid = 1'b0;
  logic hs_prev    = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      seen_valid = 1'b0;
      hs_prev    = 1'b0;
    end else begin
      if (hs_prev) chk("ready_after_rsp", {31'd0, o_req_ready}, {31'd0, !i_flush});
      hs_prev = 1'b0;
      if (o_rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: o_rsp_valid=1 data=0x%08h, required no response", o_rsp_data);
        end else begin
          if (!seen_valid) begin
            chk("latency", cyc - acc_q[0] + 1, lat_q[0]);
            seen_valid = 1'b1;
          end
          chk("rsp_data", o_rsp_data, exp_q[0]);
          chk("rsp_tag", {27'd0, o_rsp_tag}, {27'd0, tag_q[0]});
          chk("req_ready_in_done", {31'd0, o_req_ready}, 32'd0);
          chk("busy_in_done", {31'd0, o_busy}, 32'd1);
          if (i_rsp_ready) begin
            void'(exp_q.pop_front());
            void'(tag_q.pop_front());
            void'(lat_q.pop_front());
            void'(acc_q.pop_front());
            seen_valid = 1'b0;
            hs_prev    = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t dir[12];

  // ---------------- main sequence ----------------
  initial begin
    int n;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    dir[0]  = '{OP_DIVU, 32'd100,          32'd7,          32'd14};
    dir[1]  = '{OP_REMU, 32'd100,          32'd7,          32'd2};
    dir[2]  = '{OP_DIV,  32'hFFFF_FF9C,    32'd7,          32'hFFFF_FFF2};
    dir[3]  = '{OP_REM,  32'hFFFF_FF9C,    32'd7,          32'hFFFF_FFFE};
    dir[4]  = '{OP_REM,  32'd100,          32'hFFFF_FFF9,  32'd2};
    dir[5]  = '{OP_DIVU, 32'd5,            32'd0,          32'hFFFF_FFFF};
    dir[6]  = '{OP_REMU, 32'd5,            32'd0,          32'd5};
    dir[7]  = '{OP_DIV,  32'h8000_0000,    32'hFFFF_FFFF,  32'h8000_0000};
    dir[8]  = '{OP_REM,  32'h8000_0000,    32'hFFFF_FFFF,  32'd0};
    dir[9]  = '{OP_DIVU, 32'hFFFF_FFFF,    32'hFFFF_FFFE,  32'd1};
    dir[10] = '{OP_REMU, 32'hFFFF_FFFF,    32'hFFFF_FFFE,  32'd1};
    dir[11] = '{OP_DIV,  32'd7,            32'hFFFF_FFFE,  32'hFFFF_FFFD};

    // Reset values while reset is held.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'd0, o_req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("rst_rsp_data", o_rsp_data, 32'd0);
    chk("rst_rsp_tag", {27'd0, o_rsp_tag}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    rst = 1'b0;

    // Pin the reference model against hand-computed values.
    foreach (dir[i]) chk($sformatf("model_pin_%0d", i), model(dir[i].op, dir[i].a, dir[i].b), dir[i].exp);

    // Directed cases, response consumed immediately.
    foreach (dir[i]) begin
      send(dir[i].op, dir[i].a, dir[i].b, 5'(i + 1), 1'b1, dir[i].exp);
      wait_drain();
    end

    // Hold the response for five cycles: data/tag stable, no new request accepted.
    rdy_force = 1'b0;
    @(posedge clk);
    send(OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd21, 1'b1, 32'd1);
    n = 0;
    while (!o_rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("hold_valid_seen", {31'd0, o_rsp_valid}, 32'd1);
    repeat (5) @(negedge clk);
    rdy_force = 1'b1;
    wait_drain();

    // Flush during CALC iteration 10: back to IDLE, no response.
    send(OP_DIVU, 32'd1000, 32'd3, 5'd9, 1'b0, 32'd0);
    repeat (10) @(posedge clk);
    #1 i_flush = 1'b1;
    @(posedge clk);
    #1 i_flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", {31'd0, o_busy}, 32'd0);
    chk("flush_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("flush_req_ready", {31'd0, o_req_ready}, 32'd1);
    repeat (40) @(negedge clk);

    // Flush while idle masks o_req_ready.
    i_flush = 1'b1;
    #1 chk("flush_idle_ready", {31'd0, o_req_ready}, 32'd0);
    @(posedge clk);
    #1 i_flush = 1'b0;

    // Asynchronous reset mid-CALC: outputs return to reset values before the next edge.
    send(OP_DIVU, 32'd12345, 32'd67, 5'd17, 1'b0, 32'd0);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("arst_rsp_data", o_rsp_data, 32'd0);
    chk("arst_rsp_tag", {27'd0, o_rsp_tag}, 32'd0);
    chk("arst_busy", {31'd0, o_busy}, 32'd0);
    chk("arst_req_ready", {31'd0, o_req_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    // Randomized traffic with random response back-pressure.
    rdy_rand = 1'b1;
    for (int k = 0; k < 150; k++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0: begin a = $urandom(); b = 32'd0; end
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2, 3: begin
          a = $urandom_range(0, 200);
          b = $urandom_range(1, 20);
          if ($urandom_range(0, 1) == 1) a = -a;
          if ($urandom_range(0, 1) == 1) b = -b;
        end
        default: begin
          a = $urandom();
          b = $urandom() >> $urandom_range(0, 31);
        end
      endcase
      send(op, a, b, 5'($urandom_range(0, 31)), 1'b1, model(op, a, b));
    end
    wait_drain();
    rdy_rand = 1'b0;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
